fp_align_shifter: RTL and testbench
===================================

Name: fp_align_shifter

Overview:
- Mantissa alignment stage of the FP adder. Sits directly downstream of the exponent subtractor.
- Accepts the shift magnitude, select code and result exponent from that stage, together with both operand mantissas.
- Right-shifts the smaller-exponent mantissa iteratively, STEP bits per cycle, appending guard/round/sticky bits.
- Presents the aligned pair to the mantissa add stage over a valid/ready handshake.

Parameters:
MANT_W, 24, mantissa width including hidden bit
STEP, 4, maximum right-shift distance per cycle (1..MANT_W+3)

Ports:
clk  input  1  clock, rising-edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream operands valid
in_ready  output  1  block can accept operands
mant_a  input  MANT_W  mantissa of operand A
mant_b  input  MANT_W  mantissa of operand B
shift_mag  input  9  exponent difference magnitude from subtractor
select  input  2  0 = no shift, 1 = shift A, 2 = shift B, 3 = treated as 0
exp_in  input  8  larger exponent from subtractor
out_valid  output  1  aligned result valid
out_ready  input  1  downstream accepts result
out_big  output  MANT_W+3  unshifted operand, {mant,3'b000}
out_small  output  MANT_W+3  shifted operand, {mant,G,R,S}
out_exp  output  8  registered exp_in
out_swap  output  1  1 when A was the shifted operand (select==1)

Behaviour:
- Reset (async, rst_n low): state=IDLE; out_valid=0; out_big, out_small, out_exp and out_swap=0; remaining counter=0. Takes effect immediately, including mid-SHIFT or DONE; any in-flight operation is discarded.
- in_ready = (state==IDLE); reads 1 during and after reset. No overlap: one operation in flight at a time.
- IDLE: on in_valid && in_ready:
  - big <= {unshifted mant,3'b000}; small <= {shifted mant,3'b000}.
  - select 0/3: big=A, small=B, swap=0, remaining=0.
  - select 1: big=B, small=A, swap=1.
  - select 2: big=A, small=B, swap=0.
  - remaining <= min(shift_mag, MANT_W+3); i.e. saturates at 27 for the default MANT_W.
  - exp_in is latched.
  - Next state: SHIFT if remaining≠0, else DONE.
- SHIFT, each cycle:
  - k = min(STEP, remaining).
  - small <= small >> k, with new bit0 = (shifted bit0) OR (OR of all k bits shifted out, including the old bit0).
  - remaining <= remaining − k. On reaching 0 go to DONE.
- DONE:
  - out_valid=1; all outputs held stable until out_ready.
  - On out_valid && out_ready → IDLE next cycle; out_valid drops.
  - Outputs keep their last value after the handshake.
- Arithmetic contract: out_small equals exact right shift of {mant,3'b000} by the saturated distance, with bit0 set iff any nonzero bit was lost or bit0 was already set.
  - Saturation case: all bits zero except bit0 = |mant.
- Latency, accept to out_valid: 1 + ceil(sat_shift / STEP) cycles. Zero shift gives 1 cycle.
- out_valid is never asserted while state≠DONE.
- in_valid while busy is ignored; upstream must hold its data.
- Widths: shift_mag bit 8 is included in the saturation compare, so values ≥27 all saturate.

Test Plan:
- select=0, shift_mag=0, mant_a=0x800000, mant_b=0xC00000 → 1 cycle later: out_valid=1, out_big=0x4000000, out_small=0x6000000, out_swap=0, out_exp=exp_in.
- select=2, shift_mag=5, mant_a=0x800000, mant_b=0x800001 → out_valid 3 cycles after accept; out_small=0x0200001 (sticky set), out_big=0x4000000, out_swap=0.
- select=1, shift_mag=30, mant_a=0x000001, mant_b=0x900000 → saturates to 27; out_valid 8 cycles after accept; out_small=0x0000001, out_big=0x4800000, out_swap=1.
- select=2, shift_mag=27, mant_b=0x800000 → out_small=0x0000001. With shift_mag=3 and mant_b=0x000007 instead → out_small=0x0000007 (no sticky added beyond lost bits = 0).
- Backpressure: hold out_ready=0 for 5 cycles in DONE → outputs bit-stable, in_ready=0, new in_valid ignored. Raise out_ready → IDLE next cycle, in_ready=1.
- Assert rst_n low mid-SHIFT (shift_mag=20) → out_valid=0 and outputs zero immediately. After release: in_ready=1, and a fresh transaction completes normally.

Source files
------------

// File: rtl/fp_align_shifter.sv
// Mantissa alignment stage of the FP adder: right-shifts the smaller-exponent
// mantissa STEP bits per cycle with guard/round/sticky, then hands the pair on.
module fp_align_shifter #(
  parameter int MANT_W = 24,
  parameter int STEP   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [MANT_W-1:0]   mant_a,
  input  logic [MANT_W-1:0]   mant_b,
  input  logic [8:0]          shift_mag,
  input  logic [1:0]          select,
  input  logic [7:0]          exp_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [MANT_W+2:0]   out_big,
  output logic [MANT_W+2:0]   out_small,
  output logic [7:0]          out_exp,
  output logic                out_swap
);

  localparam int W     = MANT_W + 3;
  localparam int CNT_W = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [W-1:0]       big_q, big_d;
  logic [W-1:0]       small_q, small_d;
  logic [7:0]         exp_q, exp_d;
  logic               swap_q, swap_d;
  logic [CNT_W-1:0]   rem_q, rem_d;

  logic [CNT_W-1:0]   satShift;
  logic [CNT_W-1:0]   stepK;
  logic               lostBits;

  // Distances of W or more shift everything out; bit 8 of shift_mag takes part.
  always_comb begin
    if (int'(shift_mag) >= W) begin
      satShift = CNT_W'(W);
    end else begin
      satShift = CNT_W'(shift_mag);
    end
  end

  // Per-cycle shift amount and the OR of every bit it drops (old sticky included).
  always_comb begin
    if (int'(rem_q) > STEP) begin
      stepK = CNT_W'(STEP);
    end else begin
      stepK = rem_q;
    end
    lostBits = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (i < int'(stepK)) begin
        lostBits = lostBits | small_q[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    big_d   = big_q;
    small_d = small_q;
    exp_d   = exp_q;
    swap_d  = swap_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          exp_d = exp_in;
          case (select)
            2'd1: begin
              big_d   = {mant_b, 3'b000};
              small_d = {mant_a, 3'b000};
              swap_d  = 1'b1;
              rem_d   = satShift;
            end
            2'd2: begin
              big_d   = {mant_a, 3'b000};
              small_d = {mant_b, 3'b000};
              swap_d  = 1'b0;
              rem_d   = satShift;
            end
            default: begin
              big_d   = {mant_a, 3'b000};
              small_d = {mant_b, 3'b000};
              swap_d  = 1'b0;
              rem_d   = '0;
            end
          endcase
          state_d = (rem_d != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        small_d = (small_q >> stepK) | {{(W-1){1'b0}}, lostBits};
        rem_d   = rem_q - stepK;
        if (rem_d == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      big_q   <= '0;
      small_q <= '0;
      exp_q   <= '0;
      swap_q  <= 1'b0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      big_q   <= big_d;
      small_q <= small_d;
      exp_q   <= exp_d;
      swap_q  <= swap_d;
      rem_q   <= rem_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_big   = big_q;
  assign out_small = small_q;
  assign out_exp   = exp_q;
  assign out_swap  = swap_q;

endmodule

// File: tb/tb_fp_align_shifter.sv
// Directed self-checking bench for fp_align_shifter with hand-computed vectors.
module tb_fp_align_shifter;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] mant_a;
  logic [23:0] mant_b;
  logic [8:0]  shift_mag;
  logic [1:0]  select;
  logic [7:0]  exp_in;
  logic        out_valid;
  logic        out_ready;
  logic [26:0] out_big;
  logic [26:0] out_small;
  logic [7:0]  out_exp;
  logic        out_swap;

  int checks;
  int failures;
  int lat;

  fp_align_shifter #(.MANT_W(24), .STEP(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .mant_a(mant_a),
    .mant_b(mant_b),
    .shift_mag(shift_mag),
    .select(select),
    .exp_in(exp_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_big(out_big),
    .out_small(out_small),
    .out_exp(out_exp),
    .out_swap(out_swap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Offer one operation, then count edges from the accept edge until out_valid.
  task automatic applyStimulus(input logic [1:0] sel, input logic [8:0] mag,
                               input logic [23:0] a, input logic [23:0] b,
                               input logic [7:0] e, output int latency);
    @(negedge clk);
    in_valid  = 1'b1;
    select    = sel;
    shift_mag = mag;
    mant_a    = a;
    mant_b    = b;
    exp_in    = e;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    latency  = 1;
    while (!out_valid && latency < 200) begin
      @(posedge clk);
      #1;
      latency++;
    end
  endtask

  task automatic checkResult(input string tag, input int latency, input int expLat,
                             input logic [26:0] expBig, input logic [26:0] expSmall,
                             input logic [7:0] expExp, input logic expSwap);
    checkOutput({tag, "_latency"}, 32'(latency), 32'(expLat));
    checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
    checkOutput({tag, "_ready"}, 32'(in_ready), 32'd0);
    checkOutput({tag, "_big"}, 32'(out_big), 32'(expBig));
    checkOutput({tag, "_small"}, 32'(out_small), 32'(expSmall));
    checkOutput({tag, "_exp"}, 32'(out_exp), 32'(expExp));
    checkOutput({tag, "_swap"}, 32'(out_swap), 32'(expSwap));
  endtask

  task automatic releaseResult(input string tag, input logic [26:0] expSmall);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput({tag, "_rel_valid"}, 32'(out_valid), 32'd0);
    checkOutput({tag, "_rel_ready"}, 32'(in_ready), 32'd1);
    checkOutput({tag, "_rel_hold"}, 32'(out_small), 32'(expSmall));
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    mant_a    = '0;
    mant_b    = '0;
    shift_mag = '0;
    select    = '0;
    exp_in    = '0;

    #3;
    checkOutput("rst_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_big", 32'(out_big), 32'd0);
    checkOutput("rst_small", 32'(out_small), 32'd0);
    checkOutput("rst_exp", 32'(out_exp), 32'd0);
    checkOutput("rst_swap", 32'(out_swap), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] zero shift, select 0");
    applyStimulus(2'd0, 9'd0, 24'h800000, 24'hC00000, 8'h85, lat);
    checkResult("sel0", lat, 1, 27'h4000000, 27'h6000000, 8'h85, 1'b0);
    releaseResult("sel0", 27'h6000000);

    $display("[TB] select 3 ignores shift_mag");
    applyStimulus(2'd3, 9'd10, 24'h123456, 24'h654321, 8'h10, lat);
    checkResult("sel3", lat, 1, 27'h091A2B0, 27'h32A1908, 8'h10, 1'b0);
    releaseResult("sel3", 27'h32A1908);

    $display("[TB] shift B by 5 with sticky, then backpressure");
    applyStimulus(2'd2, 9'd5, 24'h800000, 24'h800001, 8'h7F, lat);
    checkResult("sel2s5", lat, 3, 27'h4000000, 27'h0200001, 8'h7F, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid  = 1'b1;
      select    = 2'd1;
      shift_mag = 9'd3;
      mant_a    = 24'hFFFFFF;
      mant_b    = 24'h000001;
      exp_in    = 8'hEE;
      @(posedge clk);
      #1;
      checkOutput("bp_ready", 32'(in_ready), 32'd0);
      checkOutput("bp_valid", 32'(out_valid), 32'd1);
      checkOutput("bp_big", 32'(out_big), 32'h4000000);
      checkOutput("bp_small", 32'(out_small), 32'h0200001);
      checkOutput("bp_exp", 32'(out_exp), 32'h7F);
    end
    in_valid = 1'b0;
    releaseResult("bp", 27'h0200001);
    @(posedge clk);
    #1;
    checkOutput("bp_no_ghost", 32'(out_valid), 32'd0);

    $display("[TB] shift A saturating from 30 to 27");
    applyStimulus(2'd1, 9'd30, 24'h000001, 24'h900000, 8'h40, lat);
    checkResult("sat30", lat, 8, 27'h4800000, 27'h0000001, 8'h40, 1'b1);
    releaseResult("sat30", 27'h0000001);

    $display("[TB] shift exactly 27 and shift 3 with no lost bits");
    applyStimulus(2'd2, 9'd27, 24'h000000, 24'h800000, 8'h01, lat);
    checkResult("sat27", lat, 8, 27'h0000000, 27'h0000001, 8'h01, 1'b0);
    releaseResult("sat27", 27'h0000001);
    applyStimulus(2'd2, 9'd3, 24'h000000, 24'h000007, 8'h02, lat);
    checkResult("s3", lat, 2, 27'h0000000, 27'h0000007, 8'h02, 1'b0);
    releaseResult("s3", 27'h0000007);

    $display("[TB] shift_mag bit 8 set saturates");
    applyStimulus(2'd1, 9'h101, 24'h000000, 24'h000003, 8'h03, lat);
    checkResult("bit8", lat, 8, 27'h0000018, 27'h0000000, 8'h03, 1'b1);
    releaseResult("bit8", 27'h0000000);

    $display("[TB] reset during shift");
    @(negedge clk);
    in_valid  = 1'b1;
    select    = 2'd2;
    shift_mag = 9'd20;
    mant_a    = 24'hABCDEF;
    mant_b    = 24'hFFFFFF;
    exp_in    = 8'h99;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("mid_busy", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_valid", 32'(out_valid), 32'd0);
    checkOutput("mid_rst_ready", 32'(in_ready), 32'd1);
    checkOutput("mid_rst_big", 32'(out_big), 32'd0);
    checkOutput("mid_rst_small", 32'(out_small), 32'd0);
    checkOutput("mid_rst_exp", 32'(out_exp), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("post_rst_ready", 32'(in_ready), 32'd1);

    $display("[TB] fresh multi-step transaction after reset");
    applyStimulus(2'd1, 9'd9, 24'h000101, 24'hFFFFFF, 8'h55, lat);
    checkResult("fresh", lat, 4, 27'h7FFFFF8, 27'h0000005, 8'h55, 1'b1);
    releaseResult("fresh", 27'h0000005);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
